// File: rtl/fb_pkg.sv
// Shared definitions for the dual-buffered frame store: controller states and default geometry.
package fb_pkg;
  localparam int DEF_H_RES     = 640;
  localparam int DEF_V_RES     = 480;
  localparam int DEF_CW        = 4;
  localparam int DEF_SPLIT_ROW = 120;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_READY,
    ST_DRAW,
    ST_HALTED,
    ST_DRAINED
  } fb_state_t;
endpackage

// File: rtl/gen_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle read latency).
// No backpressure; contents are not reset.
module gen_ram #(
  parameter int dWidth = 8,
  parameter int aWidth = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [aWidth-1:0] waddr,
  input  logic [dWidth-1:0] din,
  input  logic [aWidth-1:0] raddr,
  output logic [dWidth-1:0] dout
);
  logic [dWidth-1:0] mem [0:(1<<aWidth)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    dout <= mem[raddr];
  end
endmodule

// File: rtl/fb_dual_buffer_ctrl.sv
// Ping-pong frame buffer: one bank scanned out while the other is cleared then drawn; swap after drain.
// Read latency 2 cycles; no backpressure, writes outside DRAW or out of range are dropped and flagged.
module fb_dual_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int CW         = DEF_CW,
  parameter int SPLIT_ROW  = DEF_SPLIT_ROW,
  localparam int NPIX      = H_RES * V_RES,
  localparam int AW        = $clog2(NPIX),
  localparam int RW        = $clog2(V_RES),
  localparam int CLW       = $clog2(H_RES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vggo,
  input  logic          halt,
  input  logic          lrq_empty,
  input  logic          line_done,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_color,
  input  logic [RW-1:0] row,
  input  logic [CLW-1:0] col,
  output logic [CW-1:0] red_out,
  output logic [CW-1:0] green_out,
  output logic [CW-1:0] blue_out,
  output logic          disp_sel,
  output logic          clearing,
  output logic          wr_drop
);
  fb_state_t     state, state_nx;
  logic [AW-1:0] clr_cnt;
  logic          vggo_q, halt_q, vggo_lat;
  logic          vggo_rise, halt_rise, clr_last, swap;

  assign vggo_rise = vggo & ~vggo_q;
  assign halt_rise = halt & ~halt_q;
  assign clr_last  = (32'(clr_cnt) == NPIX - 1);
  assign clearing  = (state == ST_CLEAR);
  assign swap      = (state == ST_DRAINED) && line_done;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_CLEAR:   if (clr_last) state_nx = (vggo_lat || vggo_rise) ? ST_DRAW : ST_READY;
      ST_READY:   if (vggo_rise) state_nx = ST_DRAW;
      ST_DRAW:    if (halt_rise) state_nx = ST_HALTED;
      ST_HALTED:  if (lrq_empty) state_nx = ST_DRAINED;
      ST_DRAINED: if (line_done) state_nx = ST_CLEAR;
      default:    state_nx = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CLEAR;
      disp_sel <= 1'b0;
      clr_cnt  <= '0;
      vggo_q   <= 1'b0;
      halt_q   <= 1'b0;
      vggo_lat <= 1'b0;
    end else begin
      state  <= state_nx;
      vggo_q <= vggo;
      halt_q <= halt;
      // a start request seen during the clear pass is remembered until drawing begins
      if (state == ST_CLEAR && vggo_rise) vggo_lat <= 1'b1;
      if (state_nx == ST_DRAW)            vggo_lat <= 1'b0;
      if (state == ST_CLEAR)  clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      else if (swap)          clr_cnt <= '0;
      if (swap) disp_sel <= ~disp_sel;
    end
  end

  // Write port: the clear pass owns the draw bank; otherwise accepted pixel writes.
  logic          wr_ok, ram_we;
  logic [AW-1:0] ram_waddr;
  logic [CW-1:0] ram_din;

  assign wr_ok     = wr_en && (state == ST_DRAW) && (32'(wr_addr) < NPIX);
  assign ram_we    = clearing || wr_ok;
  assign ram_waddr = clearing ? clr_cnt : wr_addr;
  assign ram_din   = clearing ? '0 : wr_color;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_drop <= 1'b0;
    else     wr_drop <= wr_en && !wr_ok;
  end

  // Read port: linear address kept at full width so oversized row/col never aliases.
  logic [31:0]   rd_lin;
  logic          rd_oob;
  logic [CW-1:0] dout_a, dout_b, pix;
  logic          sel_q, oob_q, top_q;

  assign rd_lin = 32'(row) * 32'(H_RES) + 32'(col);
  assign rd_oob = (32'(row) >= V_RES) || (32'(col) >= H_RES) || (rd_lin >= NPIX);

  gen_ram #(.dWidth(CW), .aWidth(AW)) u_bank_a (
    .clk(clk), .we(ram_we && disp_sel), .waddr(ram_waddr), .din(ram_din),
    .raddr(rd_lin[AW-1:0]), .dout(dout_a)
  );

  gen_ram #(.dWidth(CW), .aWidth(AW)) u_bank_b (
    .clk(clk), .we(ram_we && !disp_sel), .waddr(ram_waddr), .din(ram_din),
    .raddr(rd_lin[AW-1:0]), .dout(dout_b)
  );

  assign pix = oob_q ? '0 : (sel_q ? dout_b : dout_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b0;
      oob_q     <= 1'b1;
      top_q     <= 1'b0;
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else begin
      sel_q     <= disp_sel;
      oob_q     <= rd_oob;
      top_q     <= (32'(row) <= SPLIT_ROW);
      red_out   <= top_q ? pix : '0;
      green_out <= top_q ? '0 : pix;
      blue_out  <= '0;
    end
  end
endmodule

// File: tb/tb_fb_dual_buffer_ctrl.sv
// Directed frame sequence with random pixel traffic, checked against a bank-array model.
module tb_fb_dual_buffer_ctrl;
  localparam int H = 8, V = 4, CW = 4, SP = 1, NP = H * V, AW = $clog2(NP);
  localparam int H2 = 6, V2 = 3, NP2 = H2 * V2;

  logic clk = 1'b0, rst = 1'b1;
  logic vggo = 1'b0, halt = 1'b0, lrq_empty = 1'b0, line_done = 1'b0;
  logic wr_en = 1'b0, wr_en2 = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_color = '0;
  logic [1:0] row = '0;
  logic [2:0] col = '0;
  logic [CW-1:0] red, green, blue, red2, green2, blue2;
  logic disp_sel, clearing, wr_drop, disp_sel2, clearing2, wr_drop2;

  int errors = 0, checks = 0;
  int mem [2][NP];
  int mem2[2][NP2];
  int mdisp = 0;
  int n;

  always #5 clk = ~clk;

  fb_dual_buffer_ctrl #(.H_RES(H), .V_RES(V), .CW(CW), .SPLIT_ROW(SP)) dut (
    .clk(clk), .rst(rst), .vggo(vggo), .halt(halt), .lrq_empty(lrq_empty),
    .line_done(line_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_color(wr_color),
    .row(row), .col(col), .red_out(red), .green_out(green), .blue_out(blue),
    .disp_sel(disp_sel), .clearing(clearing), .wr_drop(wr_drop)
  );

  fb_dual_buffer_ctrl #(.H_RES(H2), .V_RES(V2), .CW(CW), .SPLIT_ROW(SP)) dut2 (
    .clk(clk), .rst(rst), .vggo(vggo), .halt(halt), .lrq_empty(lrq_empty),
    .line_done(line_done), .wr_en(wr_en2), .wr_addr(wr_addr), .wr_color(wr_color),
    .row(row), .col(col), .red_out(red2), .green_out(green2), .blue_out(blue2),
    .disp_sel(disp_sel2), .clearing(clearing2), .wr_drop(wr_drop2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with clearing high; optionally raises vggo during clear cycle vggo_at.
  task automatic wait_clear(input int vggo_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!clearing) break;
      cnt++;
      if (cnt == vggo_at) vggo = 1'b1;
      step();
    end
    vggo = 1'b0;
  endtask

  task automatic model_swap();
    mdisp ^= 1;
    for (int a = 0; a < NP; a++)  mem[mdisp ^ 1][a] = 0;
    for (int a = 0; a < NP2; a++) mem2[mdisp ^ 1][a] = 0;
  endtask

  task automatic write_px(input int a, input int c, input string tag);
    wr_en = 1'b1; wr_addr = AW'(a); wr_color = CW'(c);
    step();
    chk(tag, wr_drop, 0);
    wr_en = 1'b0;
    mem[mdisp ^ 1][a] = c;
  endtask

  task automatic rand_writes(input int cnt);
    for (int i = 0; i < cnt; i++)
      write_px($urandom_range(0, NP - 1), $urandom_range(0, 15), "rand_wr_drop");
  endtask

  task automatic go_draw();
    vggo = 1'b1; step(); vggo = 1'b0;
  endtask

  task automatic end_frame();
    halt = 1'b1; step(); halt = 1'b0;
    lrq_empty = 1'b1; step(); lrq_empty = 1'b0;
    line_done = 1'b1; step(); line_done = 1'b0;
    model_swap();
  endtask

  task automatic read_chk(input int r, input int c);
    int pix, pix2;
    row = 2'(r); col = 3'(c);
    step(); step();
    pix  = (r < V && c < H) ? mem[mdisp][r * H + c] : 0;
    pix2 = (r < V2 && c < H2) ? mem2[mdisp][r * H2 + c] : 0;
    chk($sformatf("red r%0d c%0d", r, c),    red,    (r <= SP) ? pix : 0);
    chk($sformatf("green r%0d c%0d", r, c),  green,  (r <= SP) ? 0 : pix);
    chk($sformatf("blue r%0d c%0d", r, c),   blue,   0);
    chk($sformatf("red2 r%0d c%0d", r, c),   red2,   (r <= SP) ? pix2 : 0);
    chk($sformatf("green2 r%0d c%0d", r, c), green2, (r <= SP) ? 0 : pix2);
    chk($sformatf("blue2 r%0d c%0d", r, c),  blue2,  0);
  endtask

  task automatic rand_reads(input int cnt);
    for (int i = 0; i < cnt; i++) read_chk($urandom_range(0, V - 1), $urandom_range(0, H - 1));
  endtask

  initial begin
    row = 2'd1; col = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_red", red, 0);
    chk("rst_green", green, 0);
    chk("rst_wr_drop", wr_drop, 0);
    chk("rst_disp_sel", disp_sel, 0);
    chk("rst_clearing", clearing, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Frame 1: plain clear into READY, then draw bank B.
    wait_clear(-1, n);
    chk("clear_len_first", n, NP);
    chk("disp_sel_ready", disp_sel, 0);
    wr_en = 1'b1; wr_addr = AW'(10); wr_color = 4'hF;
    step();
    chk("drop_in_ready", wr_drop, 1);
    wr_en = 1'b0;
    step();
    chk("drop_one_cycle", wr_drop, 0);
    go_draw();
    rand_writes(12);
    write_px(9, 'hA, "wr_addr9");
    write_px(19, 'h5, "wr_addr19");
    wr_addr = AW'(6); wr_color = 4'h7; wr_en2 = 1'b1;
    step();
    chk("d2_accept", wr_drop2, 0);
    mem2[mdisp ^ 1][6] = 7;
    wr_addr = AW'(20); wr_color = 4'h3;
    step();
    chk("d2_drop_oob_addr", wr_drop2, 1);
    wr_en2 = 1'b0;
    halt = 1'b1; step(); halt = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(11); wr_color = 4'h9;
    step();
    chk("drop_in_halted", wr_drop, 1);
    wr_en = 1'b0;
    lrq_empty = 1'b1; step(); lrq_empty = 1'b0;
    chk("disp_before_swap", disp_sel, 0);
    line_done = 1'b1; step(); line_done = 1'b0;
    model_swap();
    chk("disp_swap1", disp_sel, 1);
    chk("clearing_after_swap", clearing, 1);

    // Frame 2: vggo during clear goes straight to DRAW.
    wait_clear(10, n);
    chk("clear_len_latched", n, NP);
    write_px(3, 6, "draw_direct_no_ready");
    read_chk(1, 1);
    read_chk(2, 3);
    read_chk(1, 2);
    read_chk(1, 0);
    read_chk(0, 6);
    read_chk(0, 7);
    read_chk(3, 0);
    read_chk(2, 6);
    rand_reads(10);
    rand_writes(10);
    end_frame();
    chk("disp_swap2", disp_sel, 0);

    // Frame 3: clear, READY, draw bank B again.
    wait_clear(-1, n);
    chk("clear_len_f3", n, NP);
    rand_reads(10);
    go_draw();
    rand_writes(10);
    write_px(9, 'hA, "wr_addr9_f3");
    end_frame();
    chk("disp_swap3", disp_sel, 1);

    // Frame 4: reset while HALTED abandons the frame.
    wait_clear(-1, n);
    chk("clear_len_f4", n, NP);
    go_draw();
    halt = 1'b1; step(); halt = 1'b0;
    read_chk(1, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_disp_sel", disp_sel, 0);
    chk("async_rst_clearing", clearing, 1);
    chk("async_rst_red", red, 0);
    chk("async_rst_green", green, 0);
    chk("async_rst_blue", blue, 0);
    chk("async_rst_wr_drop", wr_drop, 0);
    lrq_empty = 1'b1; line_done = 1'b1;
    step(); step();
    chk("held_rst_red", red, 0);
    chk("held_rst_disp_sel", disp_sel, 0);
    lrq_empty = 1'b0; line_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    mdisp = 0;
    wait_clear(-1, n);
    chk("clear_len_post_rst", n, NP);
    chk("disp_sel_post_rst", disp_sel, 0);
    wr_en = 1'b1; wr_addr = AW'(4); wr_color = 4'h1;
    step();
    chk("drop_ready_post_rst", wr_drop, 1);
    wr_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fb_dual_buffer_ctrl.md
FB_DUAL_BUFFER_CTRL -- requirements
Module: fb_dual_buffer_ctrl

Interface
REQ-001 Parameter H_RES, default 640: pixels per row.
REQ-002 Parameter V_RES, default 480: rows per frame.
REQ-003 Parameter CW, default 4: color word width in bits.
REQ-004 Parameter SPLIT_ROW, default 120: rows 0..SPLIT_ROW drive red, rows above drive green.
REQ-005 Derived constant AW = $clog2(H_RES*V_RES); NPIX = H_RES*V_RES.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 vggo  in  1  vector-generator start level; rising edge arms drawing.
REQ-009 halt  in  1  vector-generator halt level; rising edge ends drawing.
REQ-010 lrq_empty  in  1  line request queue empty.
REQ-011 line_done  in  1  line rasteriser idle.
REQ-012 wr_en / wr_addr / wr_color  in  1 / AW / CW  pixel write request.
REQ-013 row / col  in  $clog2(V_RES) / $clog2(H_RES)  scan position.
REQ-014 red_out / green_out / blue_out  out  CW each  display color.
REQ-015 disp_sel  out  1  bank currently displayed (0 = A, 1 = B).
REQ-016 clearing  out  1  high while the draw bank is being cleared.
REQ-017 wr_drop  out  1  one-cycle pulse when a write is rejected.

Function
REQ-018 Two banks A and B of NPIX x CW; display bank = disp_sel, draw bank = ~disp_sel.
REQ-019 FSM states CLEAR, READY, DRAW, HALTED, DRAINED; at most one transition per cycle.
REQ-020 CLEAR writes 0 to draw-bank addresses 0..NPIX-1, one per cycle; on writing NPIX-1, next state is READY.
REQ-021 A vggo rising edge arriving in CLEAR is latched; CLEAR then exits directly to DRAW, skipping READY; the latch clears on entering DRAW.
REQ-022 READY -> DRAW on a vggo rising edge.
REQ-023 DRAW -> HALTED on a halt rising edge.
REQ-024 HALTED -> DRAINED when lrq_empty=1.
REQ-025 DRAINED -> CLEAR when line_done=1; disp_sel toggles on the same edge; the clear counter resets to 0.
REQ-026 Writes are accepted only in DRAW with wr_addr < NPIX; any other wr_en=1 cycle pulses wr_drop the next cycle.
REQ-027 Read address = row*H_RES + col, computed at full width with no truncation before the compare.
REQ-028 Read latency is 2 cycles from row/col to color outputs (RAM register plus output register).
REQ-029 The bank-select travels with the read in the pipeline, so a swap never mixes banks within one returned pixel.
REQ-030 row >= V_RES or col >= H_RES yields all-zero color.
REQ-031 Color routing: row <= SPLIT_ROW drives red_out = pixel; otherwise green_out = pixel; blue_out is always 0; the unused channel is 0.
REQ-032 clearing = 1 exactly while the state is CLEAR.

Reset
REQ-033 rst asynchronously forces state CLEAR, disp_sel 0, clear counter 0, vggo latch 0, and edge-detect registers 0.
REQ-034 Under rst, all color outputs and wr_drop are 0.
REQ-035 RAM contents are not reset; the post-reset CLEAR pass zeroes the draw bank only.
REQ-036 rst asserted mid-frame abandons any draw or swap; no disp_sel toggle results.

Structure
REQ-037 Package fb_pkg holds the FSM state enum and default H_RES/V_RES/CW/SPLIT_ROW constants.
REQ-038 The existing gen_ram is instantiated twice (dWidth=CW, aWidth=AW); no other sub-module.
REQ-039 Target size is 150-300 lines of RTL.

Verification (bench uses H_RES=8, V_RES=4, SPLIT_ROW=1)
REQ-040 Reset release -> clearing high for exactly 32 cycles, then state READY, disp_sel=0.
REQ-041 vggo rises at clear cycle 10 -> DRAW entered on the cycle after the last clear write; READY never visited.
REQ-042 In DRAW write addr 9 color 0xA; then halt, lrq_empty, line_done -> disp_sel=1; read row1 col1 -> red_out=0xA two cycles later.
REQ-043 wr_en in READY, and wr_addr=32 in DRAW -> wr_drop pulses for each; RAM unchanged.
REQ-044 row=4 or col=8 -> all outputs 0; row=2 pixel 0x5 -> green_out=0x5, red_out=0.
REQ-045 rst pulse while HALTED -> async return to CLEAR, disp_sel=0, outputs 0 during rst.
